// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests tagged with PC/epoch,
// and a small buffer presenting one {pc, instr} pair per cycle to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      fetch_pc;
  logic             epoch;
  logic [CNT_W-1:0] inflight;

  logic [31:0]      tag_pc    [DEPTH];
  logic             tag_epoch [DEPTH];
  logic [PTR_W-1:0] tag_wr, tag_rd;

  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [PTR_W-1:0] buf_wr, buf_rd;
  logic [CNT_W-1:0] buf_count;

  logic             req_fire;
  logic             buf_push;
  logic             buf_pop;
  logic [SUM_W-1:0] credit_used;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Issue credit: a pop happening this cycle already frees its buffer slot,
  // which keeps the stream at one instruction per cycle with L=1.
  always_comb begin
    buf_pop        = (buf_count != '0) && !stall && !redirect_valid;
    credit_used    = SUM_W'(inflight) + SUM_W'(buf_count) - SUM_W'(buf_pop);
    imem_req_valid = rst_n && !redirect_valid && (credit_used < SUM_W'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    buf_push       = imem_rsp_valid && !redirect_valid && (tag_epoch[tag_rd] == epoch);
  end

  always_comb begin
    imem_req_addr = fetch_pc;
    valid_out     = (buf_count != '0);
    pc_out        = valid_out ? buf_pc[buf_rd]    : 32'h0000_0000;
    instr_out     = valid_out ? buf_instr[buf_rd] : NOP;
  end

  // PC, epoch and in-flight tracking; the tag FIFO survives a redirect so stale words drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      inflight <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        epoch    <= ~epoch;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire)       tag_wr <= tag_wr + PTR_W'(1);
      if (imem_rsp_valid) tag_rd <= tag_rd + PTR_W'(1);
      case ({req_fire, imem_rsp_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Instruction buffer occupancy; a redirect empties it outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wr    <= '0;
      buf_rd    <= '0;
      buf_count <= '0;
    end else if (redirect_valid) begin
      buf_wr    <= '0;
      buf_rd    <= '0;
      buf_count <= '0;
    end else begin
      if (buf_push) buf_wr <= buf_wr + PTR_W'(1);
      if (buf_pop)  buf_rd <= buf_rd + PTR_W'(1);
      if (buf_push && !buf_pop)      buf_count <= buf_count + CNT_W'(1);
      else if (!buf_push && buf_pop) buf_count <= buf_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tag_wr]    <= fetch_pc;
      tag_epoch[tag_wr] <= epoch;
    end
    if (buf_push) begin
      buf_pc[buf_wr]    <= tag_pc[tag_rd];
      buf_instr[buf_wr] <= imem_rsp_data;
    end
  end

  // The credit scheme must make these unreachable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(buf_push && (buf_count == CNT_W'(DEPTH))))
        else $error("if_fetch_unit: push into full instruction buffer");
      assert (!(imem_rsp_valid && (inflight == '0)))
        else $error("if_fetch_unit: response with nothing in flight");
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model with programmable latency,
// plus a second instance with RESET_PC near the top of the address space.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] pc_out, instr_out;
  logic        valid_out;

  logic        w_req_valid, w_ready, w_rsp_valid, w_stall, w_redir, w_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_redir_pc, w_pc, w_instr;

  int          passes = 0;
  int          fails  = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          lat    = 1;
  logic [31:0] pq_addr [$];
  int          pq_due  [$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall),
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(w_redir),
    .redirect_pc(w_redir_pc), .stall(w_stall),
    .pc_out(w_pc), .instr_out(w_instr), .valid_out(w_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then schedule memory responses.
  task automatic step();
    logic        acc, acc2;
    logic [31:0] a, a2;
    @(negedge clk);
    acc  = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    acc2 = w_req_valid && w_ready;
    a2   = w_req_addr;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (acc) begin
      pq_addr.push_back(a);
      pq_due.push_back(cyc + lat);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pq_due.size() != 0 && pq_due[0] == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pq_addr[0] ^ 32'hDEAD_0000;
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    w_rsp_valid = acc2;
    w_rsp_data  = a2 ^ 32'hDEAD_0000;
  endtask

  task automatic do_reset(input int l);
    rst_n          = 1'b0;
    lat            = l;
    pq_addr.delete();
    pq_due.delete();
    imem_rsp_valid = 1'b0;
    w_rsp_valid    = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    w_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'h0; w_stall = 1'b0;
    w_redir = 1'b0; w_redir_pc = 32'h0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_addr", imem_req_addr, 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr_out", instr_out, 32'h13);
    chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rel_addr", imem_req_addr, 32'h0);

    // Streaming with L=1; the wrap instance runs alongside
    step();
    chk("s1_addr_e1", imem_req_addr, 32'h4);
    chk("s1_valid_e1", 32'(valid_out), 32'h0);
    chk("wrap_addr_e1", w_req_addr, 32'hFFFF_FFFC);
    step();
    chk("s1_valid_e2", 32'(valid_out), 32'h1);
    chk("s1_pc_e2", pc_out, 32'h0);
    chk("s1_instr_e2", instr_out, 32'hDEAD_0000);
    chk("s1_addr_e2", imem_req_addr, 32'h8);
    chk("wrap_addr_e2", w_req_addr, 32'h0000_0000);
    chk("wrap_pc_e2", w_pc, 32'hFFFF_FFF8);
    step();
    chk("s1_pc_e3", pc_out, 32'h4);
    chk("s1_instr_e3", instr_out, 32'hDEAD_0004);
    chk("wrap_pc_e3", w_pc, 32'hFFFF_FFFC);
    step();
    chk("s1_pc_e4", pc_out, 32'h8);
    chk("wrap_pc_e4", w_pc, 32'h0000_0000);
    step();
    chk("s1_pc_e5", pc_out, 32'hC);
    chk("s1_addr_e5", imem_req_addr, 32'h14);

    // Stall for three cycles
    stall = 1'b1;
    #1;
    chk("st_req_drop", 32'(imem_req_valid), 32'h0);
    step();
    chk("st_pc_e6", pc_out, 32'hC);
    chk("st_req_e6", 32'(imem_req_valid), 32'h0);
    step();
    chk("st_pc_e7", pc_out, 32'hC);
    step();
    chk("st_pc_e8", pc_out, 32'hC);
    chk("st_valid_e8", 32'(valid_out), 32'h1);
    stall = 1'b0;
    #1;
    chk("st_resume_req", 32'(imem_req_valid), 32'h1);
    chk("st_resume_addr", imem_req_addr, 32'h14);
    step();
    chk("st_pc_e9", pc_out, 32'h10);
    step();
    chk("st_pc_e10", pc_out, 32'h14);
    step();
    chk("st_pc_e11", pc_out, 32'h18);

    // Redirect with two requests in flight, L=3
    do_reset(3);
    step();
    step();
    chk("rd_credit_full", 32'(imem_req_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("rd_no_req", 32'(imem_req_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd_addr_e3", imem_req_addr, 32'h100);
    chk("rd_valid_e3", 32'(valid_out), 32'h0);
    step();
    chk("rd_valid_e4", 32'(valid_out), 32'h0);
    chk("rd_req_e4", 32'(imem_req_valid), 32'h1);
    chk("rd_addr_e4", imem_req_addr, 32'h100);
    step();
    chk("rd_valid_e5", 32'(valid_out), 32'h0);
    chk("rd_addr_e5", imem_req_addr, 32'h104);
    step();
    step();
    chk("rd_valid_e7", 32'(valid_out), 32'h0);
    step();
    chk("rd_valid_e8", 32'(valid_out), 32'h1);
    chk("rd_pc_e8", pc_out, 32'h100);
    chk("rd_instr_e8", instr_out, 32'hDEAD_0100);
    step();
    chk("rd_pc_e9", pc_out, 32'h104);

    // Redirect coinciding with a response while stalled
    do_reset(1);
    step();
    step();
    chk("rs_pc_e2", pc_out, 32'h0);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    chk("rs_no_req", 32'(imem_req_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    chk("rs_valid_e3", 32'(valid_out), 32'h0);
    chk("rs_pc_e3", pc_out, 32'h0);
    chk("rs_instr_e3", instr_out, 32'h13);
    chk("rs_req_e3", 32'(imem_req_valid), 32'h1);
    chk("rs_addr_e3", imem_req_addr, 32'h200);
    step();
    step();
    chk("rs_pc_e5", pc_out, 32'h200);
    chk("rs_instr_e5", instr_out, 32'hDEAD_0200);

    // Redirect with credit available, then ready toggling 1-0-0-1
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    chk("rg_req_gated", 32'(imem_req_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rg_req_e1", 32'(imem_req_valid), 32'h1);
    chk("rg_addr_e1", imem_req_addr, 32'h40);
    step();
    imem_req_ready = 1'b0;
    #1;
    chk("rt_addr_e2", imem_req_addr, 32'h44);
    step();
    chk("rt_pc_e3", pc_out, 32'h40);
    chk("rt_instr_e3", instr_out, 32'hDEAD_0040);
    chk("rt_addr_e3", imem_req_addr, 32'h44);
    chk("rt_req_e3", 32'(imem_req_valid), 32'h1);
    step();
    chk("rt_valid_e4", 32'(valid_out), 32'h0);
    chk("rt_addr_e4", imem_req_addr, 32'h44);
    chk("rt_req_e4", 32'(imem_req_valid), 32'h1);
    imem_req_ready = 1'b1;
    step();
    chk("rt_valid_e5", 32'(valid_out), 32'h0);
    chk("rt_addr_e5", imem_req_addr, 32'h48);
    step();
    chk("rt_pc_e6", pc_out, 32'h44);
    step();
    chk("rt_pc_e7", pc_out, 32'h48);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
